alu_sequencer: RTL
==================

// Module: alu_sequencer
// PURPOSE
//  Sequences single operations through the combinational ALU (alu: Y_reg, B_reg, opcode -> 64-bit C_reg).
//  Accepts one request at a time over a valid/ready handshake and drives the ALU operands and opcode from internal registers.
//  Holds the ALU inputs stable for the opcode's settle time, captures C, and returns it over a valid/ready response.
//  Owns the architectural HI/LO registers written by mul/div and read by mfhi/mflo; sits between control unit and ALU.
// PARAMETERS
//  MUL_CYCLES  2  extra EXEC cycles held for opcode 01111 (mul), 0..15
//  DIV_CYCLES  4  extra EXEC cycles held for opcode 10000 (div), 0..15
// PORTS
//  clk           in   1   clock, rising edge
//  clr           in   1   asynchronous reset, active-low
//  req_valid     in   1   request present
//  req_ready     out  1   sequencer can accept (IDLE only)
//  req_opcode    in   5   ALU opcode (same encoding as alu)
//  req_a         in   32  operand driven to ALU Y_reg
//  req_b         in   32  operand driven to ALU B_reg
//  req_branch    in   1   branch condition passed to ALU branch_flag
//  alu_y         out  32  to ALU Y_reg
//  alu_b         out  32  to ALU B_reg
//  alu_opcode    out  5   to ALU opcode
//  alu_branch    out  1   to ALU branch_flag
//  alu_incpc     out  1   to ALU IncPC; constant 0
//  alu_c         in   64  from ALU C_reg
//  rsp_valid     out  1   result present
//  rsp_ready     in   1   consumer accepts result
//  rsp_lo        out  32  result low word
//  rsp_hi        out  32  result high word (0 except mul/div)
//  rsp_err       out  1   opcode not executable by ALU (jr, jal, in, out)
//  hi_q, lo_q    out  32  current HI/LO register contents
// BEHAVIOUR
//  Reset (clr=0, any time, async): state IDLE; every output and internal register = 0, except req_ready = 1.
//  States: IDLE, EXEC, RESP.
//  IDLE: req_ready=1. On req_valid&req_ready edge: latch opcode, a, b, branch into operand regs.
//    mul/div: EXEC with cnt=MUL_CYCLES/DIV_CYCLES.
//    other ALU opcodes: EXEC with cnt=0.
//    mfhi (11000): RESP directly, rsp_lo=hi_q.
//    mflo (11001): RESP directly, rsp_lo=lo_q.
//    jr/jal/in/out: RESP directly, rsp_lo=0, rsp_err=1.
//    rsp_hi=0 on all three direct paths.
//  EXEC: alu_y/alu_b/alu_opcode/alu_branch driven from latched regs, unchanged throughout.
//    cnt>0: decrement and stay.
//    cnt==0: capture rsp_lo=alu_c[31:0], rsp_hi=alu_c[63:32] and go to RESP.
//      For mul/div, same edge: hi_q<=alu_c[63:32], lo_q<=alu_c[31:0].
//  RESP: rsp_valid=1; rsp_* held stable until rsp_valid&rsp_ready edge, then IDLE.
//    req_ready rises the cycle after the response handshake; no bypass.
//  alu_* outputs are 0 in IDLE and RESP; ALU inputs change only on the accept edge and the leave-EXEC edge.
//  Latency (accept edge to rsp_valid high):
//    1 cycle: plain ops
//    1+MUL_CYCLES: mul; 1+DIV_CYCLES: div
//    0 (visible right after accept edge): mfhi/mflo/err
//  req_* ignored while not IDLE. rsp_ready ignored while not RESP.
//  Reset mid-EXEC or mid-RESP: operation lost, HI/LO cleared, no response issued.
//  HI/LO are written only by mul/div completion; mfhi/mflo issued after a reset return 0.
//  Unknown opcode (1101x-style, unused encodings 11010-11111): treated as err path.
// TESTING
//  add a=5,b=7 -> rsp_valid one cycle after accept; rsp_lo=12, rsp_hi=0, rsp_err=0.
//  mul a=0x10000,b=0x10000 (MUL_CYCLES=2) -> rsp after 3 cycles, hi=1, lo=0; then mfhi -> rsp_lo=1 with 0-cycle latency.
//  div a=17,b=5, rsp_ready held low 4 cycles -> rsp_* stable, req_ready=0 throughout;
//    after handshake, lo_q/hi_q hold the ALU div result.
//  opcode jal (10101) -> rsp_err=1, rsp_lo=0, HI/LO unchanged; br with req_branch=0, a=0x40 -> rsp_lo=0x40.
//  clr pulsed low during div EXEC -> all outputs 0 immediately, req_ready=1;
//    no rsp_valid until a new request; mflo then returns 0.
//  back-to-back: req_valid held high with rsp_ready=1 -> exactly one accept per operation;
//    req_ready low from accept through RESP handshake cycle.

Source files
------------

// File: rtl/alu_sequencer.sv
// -----------------------------------------------------------------------------
// alu_sequencer
//
// Runs one operation at a time through the external combinational ALU and
// owns the architectural HI/LO registers.
//
// Each request is latched into operand registers that drive the ALU inputs
// directly. The inputs are held stable for the opcode's settle time, the ALU
// result is captured, and the result is returned over a response handshake.
// mul/div results are also written to HI/LO. mfhi/mflo and non-executable
// opcodes are answered without going through the ALU.
//
// Handshake rules (both channels):
//   A transfer happens on the rising clk edge where valid && ready are both 1.
//   req_ready is 1 only in IDLE, and req_* are ignored in any other state.
//   rsp_valid is 1 only in RESP. rsp_* are held until the transfer, and
//   rsp_ready is ignored in any other state.
//   Neither valid depends combinationally on the opposite ready.
//
// Ports
//   clk, clr          clock (rising edge), asynchronous active-low reset
//   req_valid/ready   request handshake
//   req_opcode/a/b    ALU opcode and operands
//   req_branch        branch condition
//   alu_y/b/opcode    ALU operand and opcode drive (0 outside EXEC)
//   alu_branch        ALU branch_flag drive (0 outside EXEC)
//   alu_incpc         ALU IncPC, tied to 0
//   alu_c             ALU 64-bit result
//   rsp_valid/ready   response handshake
//   rsp_lo/hi/err     result words and the not-executable flag
//   hi_q, lo_q        architectural HI/LO contents
//   dbg_state         current FSM state (IDLE=0, EXEC=1, RESP=2)
// -----------------------------------------------------------------------------
module alu_sequencer #(
  parameter int unsigned MUL_CYCLES = 2,
  parameter int unsigned DIV_CYCLES = 4
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [4:0]  req_opcode,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic        req_branch,
  output logic [31:0] alu_y,
  output logic [31:0] alu_b,
  output logic [4:0]  alu_opcode,
  output logic        alu_branch,
  output logic        alu_incpc,
  input  logic [63:0] alu_c,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_lo,
  output logic [31:0] rsp_hi,
  output logic        rsp_err,
  output logic [31:0] hi_q,
  output logic [31:0] lo_q,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    K_PLAIN,
    K_MUL,
    K_DIV,
    K_MFHI,
    K_MFLO,
    K_ERR
  } kind_t;

  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_JR   = 5'b10100;
  localparam logic [4:0] OP_JAL  = 5'b10101;
  localparam logic [4:0] OP_IN   = 5'b10110;
  localparam logic [4:0] OP_OUT  = 5'b10111;
  localparam logic [4:0] OP_MFHI = 5'b11000;
  localparam logic [4:0] OP_MFLO = 5'b11001;

  // Control-flow and I/O opcodes, plus the unused encodings 11010..11111,
  // have no meaning for the ALU. They are answered with rsp_err.
  function automatic kind_t classify(input logic [4:0] op);
    kind_t k;
    k = K_PLAIN;
    case (op)
      OP_MUL:                      k = K_MUL;
      OP_DIV:                      k = K_DIV;
      OP_MFHI:                     k = K_MFHI;
      OP_MFLO:                     k = K_MFLO;
      OP_JR, OP_JAL, OP_IN, OP_OUT: k = K_ERR;
      default: begin
        if (op >= 5'b11010) k = K_ERR;
      end
    endcase
    return k;
  endfunction

  state_t     state;
  logic [3:0] cnt;
  kind_t      req_kind;
  logic       exec_muldiv;

  assign req_kind = classify(req_opcode);

  // During EXEC the latched opcode sits on alu_opcode. This tells us whether
  // the completing operation must also update HI/LO.
  assign exec_muldiv = (alu_opcode == OP_MUL) || (alu_opcode == OP_DIV);

  assign alu_incpc = 1'b0;
  assign dbg_state = state;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      req_ready  <= 1'b1;
      alu_y      <= 32'd0;
      alu_b      <= 32'd0;
      alu_opcode <= 5'd0;
      alu_branch <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_lo     <= 32'd0;
      rsp_hi     <= 32'd0;
      rsp_err    <= 1'b0;
      hi_q       <= 32'd0;
      lo_q       <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            rsp_hi    <= 32'd0;
            rsp_err   <= 1'b0;
            case (req_kind)
              K_MFHI: begin
                rsp_lo    <= hi_q;
                rsp_valid <= 1'b1;
                state     <= RESP;
              end
              K_MFLO: begin
                rsp_lo    <= lo_q;
                rsp_valid <= 1'b1;
                state     <= RESP;
              end
              K_ERR: begin
                rsp_lo    <= 32'd0;
                rsp_err   <= 1'b1;
                rsp_valid <= 1'b1;
                state     <= RESP;
              end
              default: begin
                // The operand registers are the ALU drive. They load here and
                // are cleared again when EXEC ends.
                alu_y      <= req_a;
                alu_b      <= req_b;
                alu_opcode <= req_opcode;
                alu_branch <= req_branch;
                if (req_kind == K_MUL)      cnt <= 4'(MUL_CYCLES);
                else if (req_kind == K_DIV) cnt <= 4'(DIV_CYCLES);
                else                        cnt <= 4'd0;
                state <= EXEC;
              end
            endcase
          end
        end

        EXEC: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            rsp_lo    <= alu_c[31:0];
            rsp_hi    <= alu_c[63:32];
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
            if (exec_muldiv) begin
              hi_q <= alu_c[63:32];
              lo_q <= alu_c[31:0];
            end
            alu_y      <= 32'd0;
            alu_b      <= 32'd0;
            alu_opcode <= 5'd0;
            alu_branch <= 1'b0;
            state      <= RESP;
          end
        end

        RESP: begin
          // req_ready rises only after the response transfer. No new request
          // can be taken in the same cycle the result leaves.
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end

        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
